// File: rtl/histogram_frame_ctrl_if.sv
// rtl/histogram_frame_ctrl_if.sv - control and readout bus between frame controller and histogram engine
interface histogram_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int HIST_WIDTH = 18
);
  logic                  clear_hist;
  logic                  enable_hist;
  logic                  hist_valid;
  logic [DATA_WIDTH-1:0] hist_bin;
  logic [1:0]            channel_sel;
  logic [HIST_WIDTH-1:0] r_hist_value;
  logic [HIST_WIDTH-1:0] g_hist_value;
  logic [HIST_WIDTH-1:0] b_hist_value;

  modport master (
    output clear_hist, enable_hist,
    input  hist_valid, hist_bin, channel_sel, r_hist_value, g_hist_value, b_hist_value
  );

  modport slave (
    input  clear_hist, enable_hist,
    output hist_valid, hist_bin, channel_sel, r_hist_value, g_hist_value, b_hist_value
  );
endinterface

// File: rtl/histogram_frame_ctrl.sv
// rtl/histogram_frame_ctrl.sv - frame sequencer and min/max/median reducer for the RGB histogram engine
// Optional readout watchdog: HIST_CTRL_TIMEOUT_EN
module histogram_frame_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int HIST_BINS       = 256,
  parameter int HIST_WIDTH      = 18,
  parameter int SUM_WIDTH       = 26,
  parameter int FRAME_DIV_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_en,
  input  logic                       frame_start,
  input  logic                       frame_end,
  input  logic                       pixel_valid,
  input  logic [FRAME_DIV_WIDTH-1:0] frame_div,
  input  logic                       overrun_clr,
  histogram_frame_ctrl_if.master     eng,
  output logic [3*DATA_WIDTH-1:0]    stat_min,
  output logic [3*DATA_WIDTH-1:0]    stat_max,
  output logic [3*DATA_WIDTH-1:0]    stat_med,
  output logic [SUM_WIDTH-1:0]       stat_count,
  output logic                       stat_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout_err
);
  typedef enum logic [2:0] {ARM, CLEAR, ACCUM, DRAIN, READ, DONE} state_t;

  state_t                     state, state_nxt;
  logic [FRAME_DIV_WIDTH-1:0] skip;
  logic [SUM_WIDTH-1:0]       pix_cnt;
  logic [SUM_WIDTH-1:0]       cum, cum_base, cum_nxt;
  logic                       found, found_base, found_nxt;
  logic                       seen, seen_base, seen_nxt;
  logic [3*DATA_WIDTH-1:0]    work_min, work_max, work_med;
  logic [3*DATA_WIDTH-1:0]    min_nxt, max_nxt, med_nxt;
  logic [DATA_WIDTH-1:0]      min_c, max_c, med_c;
  logic [HIST_WIDTH-1:0]      value;
  logic [1:0]                 ch_idx;
  logic                       bin_zero;
  logic                       start_beat, process_beat, last_beat;
  logic                       overrun_set, timeout_hit;
  logic                       clear_hist, enable_hist;

  assign eng.clear_hist  = clear_hist;
  assign eng.enable_hist = enable_hist;

  // Per-beat reduction; bin 0 of a channel restarts its running state.
  always_comb begin
    case (eng.channel_sel)
      2'd1:    value = eng.g_hist_value;
      2'd2:    value = eng.b_hist_value;
      default: value = eng.r_hist_value;
    endcase
    ch_idx       = (eng.channel_sel == 2'd3) ? 2'd2 : eng.channel_sel;
    bin_zero     = (eng.hist_bin == '0);
    start_beat   = eng.hist_valid && (eng.channel_sel == 2'd0) && bin_zero;
    process_beat = ((state == DRAIN) && start_beat) ||
                   ((state == READ) && eng.hist_valid && (eng.channel_sel != 2'd3));
    last_beat    = process_beat && (eng.channel_sel == 2'd2) &&
                   (eng.hist_bin == DATA_WIDTH'(HIST_BINS - 1));

    cum_base   = bin_zero ? '0 : cum;
    found_base = bin_zero ? 1'b0 : found;
    seen_base  = bin_zero ? 1'b0 : seen;
    min_c      = bin_zero ? '0 : work_min[ch_idx*DATA_WIDTH +: DATA_WIDTH];
    max_c      = bin_zero ? '0 : work_max[ch_idx*DATA_WIDTH +: DATA_WIDTH];
    med_c      = bin_zero ? '0 : work_med[ch_idx*DATA_WIDTH +: DATA_WIDTH];
    cum_nxt    = cum_base + SUM_WIDTH'(value);
    found_nxt  = found_base;
    seen_nxt   = seen_base;
    if (value != '0) begin
      if (!seen_base) min_c = eng.hist_bin;
      max_c    = eng.hist_bin;
      seen_nxt = 1'b1;
    end
    if (!found_base && ({cum_nxt, 1'b0} >= {1'b0, pix_cnt})) begin
      med_c     = eng.hist_bin;
      found_nxt = 1'b1;
    end
    min_nxt = work_min;
    max_nxt = work_max;
    med_nxt = work_med;
    min_nxt[ch_idx*DATA_WIDTH +: DATA_WIDTH] = min_c;
    max_nxt[ch_idx*DATA_WIDTH +: DATA_WIDTH] = max_c;
    med_nxt[ch_idx*DATA_WIDTH +: DATA_WIDTH] = med_c;
  end

  always_comb begin
    state_nxt   = state;
    overrun_set = 1'b0;
    clear_hist  = 1'b0;
    enable_hist = 1'b0;
    busy        = 1'b0;
    case (state)
      ARM: begin
        if (frame_start && start_en && (skip == '0)) state_nxt = CLEAR;
      end
      CLEAR: begin
        clear_hist = 1'b1;
        busy       = 1'b1;
        state_nxt  = ACCUM;
      end
      ACCUM: begin
        enable_hist = 1'b1;
        busy        = 1'b1;
        if (frame_end) begin
          state_nxt = DRAIN;
        end else if (frame_start) begin
          overrun_set = 1'b1;
          state_nxt   = CLEAR;
        end
      end
      DRAIN: begin
        busy        = 1'b1;
        overrun_set = frame_start;
        if (start_beat)       state_nxt = READ;
        else if (timeout_hit) state_nxt = ARM;
      end
      READ: begin
        busy        = 1'b1;
        overrun_set = frame_start;
        if (!eng.hist_valid) state_nxt = DRAIN;
        else if (last_beat)  state_nxt = DONE;
      end
      DONE: begin
        overrun_set = frame_start;
        state_nxt   = ARM;
      end
      default: state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARM;
      skip       <= '0;
      pix_cnt    <= '0;
      cum        <= '0;
      found      <= 1'b0;
      seen       <= 1'b0;
      work_min   <= '0;
      work_max   <= '0;
      work_med   <= '0;
      stat_min   <= '0;
      stat_max   <= '0;
      stat_med   <= '0;
      stat_count <= '0;
      stat_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) pix_cnt <= '0;
      else if ((state == ACCUM) && pixel_valid && (pix_cnt != '1)) pix_cnt <= pix_cnt + 1'b1;
      if (process_beat) begin
        cum      <= cum_nxt;
        found    <= found_nxt;
        seen     <= seen_nxt;
        work_min <= min_nxt;
        work_max <= max_nxt;
        work_med <= med_nxt;
      end
      stat_valid <= last_beat;
      if (last_beat) begin
        stat_min   <= min_nxt;
        stat_max   <= max_nxt;
        stat_med   <= med_nxt;
        stat_count <= pix_cnt;
      end
      if (state == DONE) skip <= frame_div;
      else if ((state == ARM) && frame_start && start_en && (skip != '0)) skip <= skip - 1'b1;
      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

`ifdef HIST_CTRL_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(4 * HIST_BINS);
  logic [WD_WIDTH-1:0] wd_cnt;

  // Count restarts whenever DRAIN is (re)entered, including after a READ gap.
  assign timeout_hit = (state == DRAIN) && !start_beat && (wd_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= (state == DRAIN) ? wd_cnt + 1'b1 : '0;
      if (timeout_hit)      timeout_err <= 1'b1;
      else if (overrun_clr) timeout_err <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_histogram_frame_ctrl.sv
// tb/tb_histogram_frame_ctrl.sv - directed self-checking bench for histogram_frame_ctrl
module tb_histogram_frame_ctrl;
  localparam int DW = 8, HB = 256, HW = 18, SW = 26, FW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start_en = 1'b0, frame_start = 1'b0, frame_end = 1'b0, pixel_valid = 1'b0;
  logic [FW-1:0] frame_div = '0;
  logic          overrun_clr = 1'b0;
  logic [3*DW-1:0] stat_min, stat_max, stat_med;
  logic [SW-1:0] stat_count;
  logic          stat_valid, busy, overrun, timeout_err;

  int hr[HB], hg[HB], hb[HB];
  int errors = 0, checks = 0, clr_cnt = 0, sv_cnt = 0;
  int c0, s0;

  always #5 clk = ~clk;

  histogram_frame_ctrl_if #(.DATA_WIDTH(DW), .HIST_WIDTH(HW)) eng();

  histogram_frame_ctrl #(
    .DATA_WIDTH(DW), .HIST_BINS(HB), .HIST_WIDTH(HW), .SUM_WIDTH(SW), .FRAME_DIV_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst), .start_en(start_en), .frame_start(frame_start),
    .frame_end(frame_end), .pixel_valid(pixel_valid), .frame_div(frame_div),
    .overrun_clr(overrun_clr), .eng(eng),
    .stat_min(stat_min), .stat_max(stat_max), .stat_med(stat_med),
    .stat_count(stat_count), .stat_valid(stat_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always @(negedge clk) begin
    if (eng.clear_hist) clr_cnt++;
    if (stat_valid) sv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < HB; i++) begin
      hr[i] = 0; hg[i] = 0; hb[i] = 0;
    end
  endtask

  task automatic pixel(input int r, input int g, input int b);
    if (eng.enable_hist) begin
      hr[r]++; hg[g]++; hb[b]++;
    end
    pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (eng.clear_hist) clear_model();
    tick();
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic readout(input int beats);
    for (int k = 0; k < beats; k++) begin
      eng.hist_valid   = 1'b1;
      eng.channel_sel  = 2'(k / HB);
      eng.hist_bin     = DW'(k % HB);
      eng.r_hist_value = HW'(hr[k % HB]);
      eng.g_hist_value = HW'(hg[k % HB]);
      eng.b_hist_value = HW'(hb[k % HB]);
      tick();
    end
    eng.hist_valid = 1'b0;
  endtask

  task automatic check_stats(input string tag, input logic [23:0] mn, input logic [23:0] mx,
                             input logic [23:0] md, input int cnt);
    check({tag, ".valid"}, stat_valid, 1);
    check({tag, ".min"}, stat_min, mn);
    check({tag, ".max"}, stat_max, mx);
    check({tag, ".med"}, stat_med, md);
    check({tag, ".count"}, stat_count, cnt);
  endtask

  initial begin
    eng.hist_valid = 1'b0; eng.hist_bin = '0; eng.channel_sel = '0;
    eng.r_hist_value = '0; eng.g_hist_value = '0; eng.b_hist_value = '0;
    clear_model();
    tick(); tick();
    check("rst.min", stat_min, 0);
    check("rst.count", stat_count, 0);
    check("rst.flags", {stat_valid, busy, overrun, timeout_err, eng.clear_hist, eng.enable_hist}, 0);
    rst = 1'b0;
    tick();

    // Frame with pixel pattern, an aborted partial readout, then a full pass
    start_en = 1'b1;
    start_frame();
    check("t1.accum", {busy, eng.enable_hist}, 2'b11);
    for (int i = 0; i < 16; i++) pixel(5, i, (i % 2) ? 255 : 0);
    end_frame();
    s0 = sv_cnt;
    readout(100);
    tick();
    readout(768);
    check_stats("t1", 24'h000005, 24'hFF0F05, 24'h000705, 16);
    tick();
    check("t1.pulse", {stat_valid, busy}, 0);
    check("t1.hold", stat_max, 24'hFF0F05);
    check("t1.once", sv_cnt - s0, 1);

    // frame_div=2: only frames 1 and 4 measured; frames 5,6 drain the skip count back to 0
    frame_div = 4'd2;
    for (int f = 1; f <= 6; f++) begin
      c0 = clr_cnt; s0 = sv_cnt;
      start_frame();
      pixel(1, 2, 3); pixel(1, 2, 3); pixel(1, 2, 3);
      end_frame();
      readout(768);
      tick();
      check($sformatf("t2.clr%0d", f), clr_cnt - c0, (f == 1 || f == 4) ? 1 : 0);
      check($sformatf("t2.sv%0d", f), sv_cnt - s0, (f == 1 || f == 4) ? 1 : 0);
    end
    check("t2.count", stat_count, 3);
    frame_div = 4'd0;

    // Empty frame; frame_start in DRAIN flags overrun even alongside overrun_clr
    start_frame();
    end_frame();
    frame_start = 1'b1; overrun_clr = 1'b1;
    tick();
    frame_start = 1'b0; overrun_clr = 1'b0;
    check("t3.setwins", {overrun, busy}, 2'b11);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t3.clr", overrun, 0);
    readout(768);
    check_stats("t3", 0, 0, 0, 0);
    tick();

    // Restart in ACCUM on a second frame_start
    start_frame();
    pixel(9, 9, 9); pixel(9, 9, 9); pixel(9, 9, 9);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t4.restart", {overrun, eng.clear_hist}, 2'b11);
    clear_model();
    tick();
    for (int i = 0; i < 5; i++) pixel(1, 1, 1);
    end_frame();
    readout(768);
    check_stats("t4", 24'h010101, 24'h010101, 24'h010101, 5);
    tick();
    check("t4.sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t4.cleared", overrun, 0);

    // Reset in the middle of READ, then a normal frame
    start_frame();
    for (int i = 0; i < 4; i++) pixel(7, 7, 7);
    end_frame();
    readout(300);
    rst = 1'b1;
    #1;
    check("t5.stats", {stat_min, stat_max, stat_med, stat_count}, 0);
    check("t5.flags", {stat_valid, busy, overrun, timeout_err}, 0);
    #2;
    rst = 1'b0;
    tick();
    start_frame();
    pixel(3, 4, 5); pixel(3, 4, 5);
    end_frame();
    readout(768);
    check_stats("t5", 24'h050403, 24'h050403, 24'h050403, 2);
    tick();

    // Readout never starts
    start_frame();
    pixel(2, 2, 2);
    end_frame();
    s0 = sv_cnt;
    for (int i = 0; i < 1030; i++) tick();
`ifdef HIST_CTRL_TIMEOUT_EN
    check("t6.timeout", {timeout_err, busy}, 2'b10);
    check("t6.nosv", sv_cnt - s0, 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t6.clr", timeout_err, 0);
`else
    check("t6.wait", {timeout_err, busy}, 2'b01);
    readout(768);
    tick();
    check("t6.sv", sv_cnt - s0, 1);
    check("t6.count", stat_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
